// File: rtl/friscv_rv32i_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// friscv_rv32i_lsu_ctrl
//
// Load/store controller for an RV32I core. It takes one decoded memory
// instruction at a time and works out the effective address, byte strobes
// and store data. It then holds the data-memory request until the memory
// acknowledges it. For loads, it aligns and sign- or zero-extends the
// returned word and writes the result back to the register file.
//
// Ports
//   aclk, srst            clock, synchronous active-high reset
//   lsu_en / lsu_ready    instruction valid / controller idle and accepting
//   lsu_load, lsu_funct3  load(1)/store(0) and RV32I width/sign code
//   lsu_rd                load destination register
//   lsu_imm12             signed offset added to lsu_rs1_val
//   lsu_rs1_val/rs2_val   base address / store data
//   lsu_error             one-cycle pulse for misaligned or illegal funct3
//   regs_rd_*             register-file write-back port
//   mem_*                 data-memory port (this block is its only master)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module friscv_rv32i_lsu_ctrl #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              lsu_en,
    output logic              lsu_ready,
    input  logic              lsu_load,
    input  logic [2:0]        lsu_funct3,
    input  logic [4:0]        lsu_rd,
    input  logic [11:0]       lsu_imm12,
    input  logic [XLEN-1:0]   lsu_rs1_val,
    input  logic [XLEN-1:0]   lsu_rs2_val,
    output logic              lsu_error,
    output logic              regs_rd_wr,
    output logic [4:0]        regs_rd_addr,
    output logic [XLEN-1:0]   regs_rd_val,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDRW-1:0]  mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_strb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              lsu_ready_q, lsu_ready_d;
    logic              lsu_error_q, lsu_error_d;
    logic              regs_rd_wr_q, regs_rd_wr_d;
    logic [4:0]        regs_rd_addr_q, regs_rd_addr_d;
    logic [XLEN-1:0]   regs_rd_val_q, regs_rd_val_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDRW-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0] mem_strb_q, mem_strb_d;
    // Instruction fields that are still needed once the request is in flight.
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              load_q, load_d;

    // Effective address, and checks on the incoming instruction.
    logic [XLEN-1:0] ea;
    logic [1:0]      ea_off;
    logic            illegal;
    logic            misaligned;
    logic            unused_ea_hi;

    assign ea           = lsu_rs1_val + {{(XLEN-12){lsu_imm12[11]}}, lsu_imm12};
    assign ea_off       = ea[1:0];
    assign unused_ea_hi = ^ea[XLEN-1:ADDRW+2];

    // Loads allow funct3 0,1,2,4,5. Stores allow 0,1,2.
    assign illegal    = lsu_load ? (lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7)
                                 : (lsu_funct3 >= 3'd3);
    // funct3[1:0] encodes the access size for both loads and stores.
    assign misaligned = (lsu_funct3[1:0] == 2'd1 && ea_off[0]) ||
                        (lsu_funct3[1:0] == 2'd2 && ea_off != 2'd0);

    // Split the read word into byte and halfword lanes.
    logic [7:0]  rd_bytes  [4];
    logic [15:0] rd_halves [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rd_bytes[gi] = mem_rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign rd_halves[gi] = mem_rdata[16*gi +: 16];
        end
    endgenerate

    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_result;

    always_comb begin
        sel_byte    = rd_bytes[off_q];
        sel_half    = rd_halves[off_q[1]];
        load_result = '0;
        case (funct3_q)
            3'd0:    load_result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'd1:    load_result = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'd4:    load_result = {{(XLEN-8){1'b0}}, sel_byte};
            3'd5:    load_result = {{(XLEN-16){1'b0}}, sel_half};
            default: load_result = mem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        lsu_ready_d    = lsu_ready_q;
        lsu_error_d    = 1'b0;
        regs_rd_wr_d   = 1'b0;
        regs_rd_addr_d = regs_rd_addr_q;
        regs_rd_val_d  = regs_rd_val_q;
        mem_en_d       = mem_en_q;
        mem_wr_d       = mem_wr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_strb_d     = mem_strb_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        rd_d           = rd_q;
        load_d         = load_q;

        case (state_q)
            ST_IDLE: begin
                if (lsu_en) begin
                    if (illegal || misaligned) begin
                        lsu_error_d = 1'b1;
                    end else begin
                        state_d     = ST_MEM;
                        lsu_ready_d = 1'b0;
                        mem_en_d    = 1'b1;
                        mem_wr_d    = !lsu_load;
                        mem_addr_d  = ea[ADDRW+1:2];
                        funct3_d    = lsu_funct3;
                        off_d       = ea_off;
                        rd_d        = lsu_rd;
                        load_d      = lsu_load;
                        case (lsu_funct3[1:0])
                            2'd0: begin
                                mem_strb_d  = 4'b0001 << ea_off;
                                mem_wdata_d = {4{lsu_rs2_val[7:0]}};
                            end
                            2'd1: begin
                                mem_strb_d  = 4'b0011 << ea_off;
                                mem_wdata_d = {2{lsu_rs2_val[15:0]}};
                            end
                            default: begin
                                mem_strb_d  = 4'b1111;
                                mem_wdata_d = lsu_rs2_val;
                            end
                        endcase
                        if (lsu_load) begin
                            mem_wdata_d = '0;
                        end
                    end
                end
            end
            ST_MEM: begin
                // The request stays frozen until the memory acknowledges it.
                if (mem_ready) begin
                    mem_en_d = 1'b0;
                    if (load_q && rd_q != 5'd0) begin
                        state_d        = ST_WB;
                        regs_rd_wr_d   = 1'b1;
                        regs_rd_addr_d = rd_q;
                        regs_rd_val_d  = load_result;
                    end else begin
                        // Stores and loads to x0 finish here without a write-back.
                        state_d     = ST_IDLE;
                        lsu_ready_d = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d     = ST_IDLE;
                lsu_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                lsu_ready_d = 1'b1;
                mem_en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q        <= ST_IDLE;
            lsu_ready_q    <= 1'b1;
            lsu_error_q    <= 1'b0;
            regs_rd_wr_q   <= 1'b0;
            regs_rd_addr_q <= '0;
            regs_rd_val_q  <= '0;
            mem_en_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_strb_q     <= '0;
            funct3_q       <= '0;
            off_q          <= '0;
            rd_q           <= '0;
            load_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            lsu_ready_q    <= lsu_ready_d;
            lsu_error_q    <= lsu_error_d;
            regs_rd_wr_q   <= regs_rd_wr_d;
            regs_rd_addr_q <= regs_rd_addr_d;
            regs_rd_val_q  <= regs_rd_val_d;
            mem_en_q       <= mem_en_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_strb_q     <= mem_strb_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            rd_q           <= rd_d;
            load_q         <= load_d;
        end
    end

    assign lsu_ready    = lsu_ready_q;
    assign lsu_error    = lsu_error_q;
    assign regs_rd_wr   = regs_rd_wr_q;
    assign regs_rd_addr = regs_rd_addr_q;
    assign regs_rd_val  = regs_rd_val_q;
    assign mem_en       = mem_en_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_strb     = mem_strb_q;

endmodule

// File: tb/tb_friscv_rv32i_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for friscv_rv32i_lsu_ctrl.
// The main part runs a table of directed load/store vectors with hand-computed
// addresses, strobes, write data and write-back values. Short hand-written
// sequences then cover these cases:
//   - lsu_en while busy
//   - mem_ready while idle
//   - reset in the middle of an access
// ---------------------------------------------------------------------------
module tb_friscv_rv32i_lsu_ctrl;

    logic        aclk = 1'b0;
    logic        srst;
    logic        lsu_en;
    logic        lsu_ready;
    logic        lsu_load;
    logic [2:0]  lsu_funct3;
    logic [4:0]  lsu_rd;
    logic [11:0] lsu_imm12;
    logic [31:0] lsu_rs1_val;
    logic [31:0] lsu_rs2_val;
    logic        lsu_error;
    logic        regs_rd_wr;
    logic [4:0]  regs_rd_addr;
    logic [31:0] regs_rd_val;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    friscv_rv32i_lsu_ctrl #(.ADDRW(16), .XLEN(32)) dut (
        .aclk(aclk), .srst(srst),
        .lsu_en(lsu_en), .lsu_ready(lsu_ready), .lsu_load(lsu_load),
        .lsu_funct3(lsu_funct3), .lsu_rd(lsu_rd), .lsu_imm12(lsu_imm12),
        .lsu_rs1_val(lsu_rs1_val), .lsu_rs2_val(lsu_rs2_val), .lsu_error(lsu_error),
        .regs_rd_wr(regs_rd_wr), .regs_rd_addr(regs_rd_addr), .regs_rd_val(regs_rd_val),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        bit          load;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        bit          exp_err;
        logic [15:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_val;
    } vec_t;

    function automatic vec_t mk(string name, bit load, logic [2:0] f3, logic [4:0] rd,
                                logic [11:0] imm, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] rdata, int delay, bit exp_err,
                                logic [15:0] exp_addr, logic [3:0] exp_strb,
                                logic [31:0] exp_wdata, logic [31:0] exp_val);
        vec_t v;
        v.name = name; v.load = load; v.f3 = f3; v.rd = rd; v.imm = imm;
        v.rs1 = rs1; v.rs2 = rs2; v.rdata = rdata; v.delay = delay;
        v.exp_err = exp_err; v.exp_addr = exp_addr; v.exp_strb = exp_strb;
        v.exp_wdata = exp_wdata; v.exp_val = exp_val;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_instr(input bit load, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [11:0] imm, input logic [31:0] rs1,
                               input logic [31:0] rs2);
        lsu_en      = 1'b1;
        lsu_load    = load;
        lsu_funct3  = f3;
        lsu_rd      = rd;
        lsu_imm12   = imm;
        lsu_rs1_val = rs1;
        lsu_rs2_val = rs2;
    endtask

    // Applies one vector from the idle state and checks every cycle until idle again.
    task automatic run_vec(input vec_t v);
        string n;
        n = v.name;
        chk({n, ".idle_ready"}, 32'(lsu_ready), 32'd1);
        drive_instr(v.load, v.f3, v.rd, v.imm, v.rs1, v.rs2);
        tick();
        lsu_en = 1'b0;
        if (v.exp_err) begin
            chk({n, ".err_pulse"}, 32'(lsu_error), 32'd1);
            chk({n, ".err_mem_en"}, 32'(mem_en), 32'd0);
            chk({n, ".err_ready"}, 32'(lsu_ready), 32'd1);
            tick();
            chk({n, ".err_cleared"}, 32'(lsu_error), 32'd0);
            chk({n, ".err_mem_en2"}, 32'(mem_en), 32'd0);
            chk({n, ".err_no_wb"}, 32'(regs_rd_wr), 32'd0);
        end else begin
            chk({n, ".mem_en"}, 32'(mem_en), 32'd1);
            chk({n, ".mem_wr"}, 32'(mem_wr), 32'(!v.load));
            chk({n, ".mem_addr"}, 32'(mem_addr), 32'(v.exp_addr));
            chk({n, ".mem_strb"}, 32'(mem_strb), 32'(v.exp_strb));
            chk({n, ".mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({n, ".busy"}, 32'(lsu_ready), 32'd0);
            chk({n, ".no_err"}, 32'(lsu_error), 32'd0);
            for (int k = 0; k < v.delay; k++) begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
                tick();
                chk({n, ".hold_en"}, 32'(mem_en), 32'd1);
                chk({n, ".hold_addr"}, 32'(mem_addr), 32'(v.exp_addr));
                chk({n, ".hold_strb"}, 32'(mem_strb), 32'(v.exp_strb));
                chk({n, ".hold_wdata"}, mem_wdata, v.exp_wdata);
            end
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            chk({n, ".mem_dropped"}, 32'(mem_en), 32'd0);
            if (v.load && v.rd != 5'd0) begin
                chk({n, ".wb_en"}, 32'(regs_rd_wr), 32'd1);
                chk({n, ".wb_addr"}, 32'(regs_rd_addr), 32'(v.rd));
                chk({n, ".wb_val"}, regs_rd_val, v.exp_val);
                chk({n, ".wb_busy"}, 32'(lsu_ready), 32'd0);
                tick();
                chk({n, ".wb_once"}, 32'(regs_rd_wr), 32'd0);
                chk({n, ".ready_back"}, 32'(lsu_ready), 32'd1);
            end else begin
                chk({n, ".no_wb"}, 32'(regs_rd_wr), 32'd0);
                chk({n, ".ready_back"}, 32'(lsu_ready), 32'd1);
                tick();
                chk({n, ".no_wb_late"}, 32'(regs_rd_wr), 32'd0);
            end
        end
        $display("[TB] vector %s applied (tests=%0d failed=%0d)", n, n_tests, n_fail);
    endtask

    vec_t vecs[21];
    vec_t sw_after;

    initial begin
        //            name            ld f3 rd  imm     rs1           rs2           rdata         dly err addr     strb  wdata         val
        vecs[0]  = mk("sw_basic",     0, 2, 0,  12'h004, 32'h00001000, 32'hDEADBEEF, 32'h0,        0, 0, 16'h0401, 4'hF, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk("lb_wait3",     1, 0, 5,  12'h003, 32'h00002000, 32'h0,        32'h80FFFFFF, 3, 0, 16'h0800, 4'h8, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mk("lbu",          1, 4, 5,  12'h003, 32'h00002000, 32'h0,        32'h80FFFFFF, 0, 0, 16'h0800, 4'h8, 32'h0,        32'h00000080);
        vecs[3]  = mk("lh_hi",        1, 1, 6,  12'h002, 32'h00000000, 32'h0,        32'h80011234, 0, 0, 16'h0000, 4'hC, 32'h0,        32'hFFFF8001);
        vecs[4]  = mk("sh_hi",        0, 1, 0,  12'h002, 32'h00000000, 32'h0000ABCD, 32'h0,        0, 0, 16'h0000, 4'hC, 32'hABCDABCD, 32'h0);
        vecs[5]  = mk("lw_misalign",  1, 2, 4,  12'h002, 32'h00000004, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[6]  = mk("sh_misalign",  0, 1, 0,  12'h001, 32'h00000000, 32'h00001234, 32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[7]  = mk("lw_rd0_neg",   1, 2, 0,  12'hFFE, 32'h00000002, 32'h0,        32'h12345678, 0, 0, 16'h0000, 4'hF, 32'h0,        32'h0);
        vecs[8]  = mk("sw_wrap",      0, 2, 0,  12'h004, 32'hFFFFFFFC, 32'h55AA55AA, 32'h0,        1, 0, 16'h0000, 4'hF, 32'h55AA55AA, 32'h0);
        vecs[9]  = mk("lhu",          1, 5, 7,  12'h001, 32'h00003001, 32'h0,        32'hFEDC0000, 0, 0, 16'h0C00, 4'hC, 32'h0,        32'h0000FEDC);
        vecs[10] = mk("sb_o3",        0, 0, 0,  12'hFFF, 32'h00000100, 32'h123456A5, 32'h0,        0, 0, 16'h003F, 4'h8, 32'hA5A5A5A5, 32'h0);
        vecs[11] = mk("ld_ill3",      1, 3, 1,  12'h000, 32'h00000000, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[12] = mk("st_ill3",      0, 3, 0,  12'h000, 32'h00000000, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[13] = mk("lw_wait1",     1, 2, 31, 12'h010, 32'h00000000, 32'h0,        32'hCAFEF00D, 1, 0, 16'h0004, 4'hF, 32'h0,        32'hCAFEF00D);
        vecs[14] = mk("lh_lo",        1, 1, 2,  12'h000, 32'h00000020, 32'h0,        32'h00007FFF, 0, 0, 16'h0008, 4'h3, 32'h0,        32'h00007FFF);
        vecs[15] = mk("lb_o1",        1, 0, 8,  12'h000, 32'h00000041, 32'h0,        32'h00009A00, 2, 0, 16'h0010, 4'h2, 32'h0,        32'hFFFFFF9A);
        vecs[16] = mk("sb_o0",        0, 0, 0,  12'h000, 32'h00000200, 32'h000000C3, 32'h0,        0, 0, 16'h0080, 4'h1, 32'hC3C3C3C3, 32'h0);
        vecs[17] = mk("lb_pos_o2",    1, 0, 9,  12'h000, 32'h00000302, 32'h0,        32'h007F0000, 0, 0, 16'h00C0, 4'h4, 32'h0,        32'h0000007F);
        vecs[18] = mk("ld_ill7",      1, 7, 1,  12'h000, 32'h00000000, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[19] = mk("st_ill5",      0, 5, 0,  12'h000, 32'h00000000, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        vecs[20] = mk("sw_misalign",  0, 2, 0,  12'h002, 32'h00000000, 32'h0,        32'h0,        0, 1, 16'h0,    4'h0, 32'h0,        32'h0);
        sw_after = mk("sw_after_rst", 0, 2, 0,  12'h008, 32'h00000100, 32'h0F0F0F0F, 32'h0,        0, 0, 16'h0042, 4'hF, 32'h0F0F0F0F, 32'h0);

        srst = 1'b1;
        lsu_en = 1'b0; lsu_load = 1'b0; lsu_funct3 = '0; lsu_rd = '0; lsu_imm12 = '0;
        lsu_rs1_val = '0; lsu_rs2_val = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) tick();

        // Reset values.
        chk("rst.lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst.lsu_error", 32'(lsu_error), 32'd0);
        chk("rst.regs_rd_wr", 32'(regs_rd_wr), 32'd0);
        chk("rst.regs_rd_addr", 32'(regs_rd_addr), 32'd0);
        chk("rst.regs_rd_val", regs_rd_val, 32'd0);
        chk("rst.mem_en", 32'(mem_en), 32'd0);
        chk("rst.mem_wr", 32'(mem_wr), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_strb", 32'(mem_strb), 32'd0);
        srst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // A new lsu_en while a store is in flight must not be captured.
        drive_instr(1'b0, 3'd2, 5'd0, 12'h000, 32'h00000080, 32'h11112222);
        tick();
        chk("busy.mem_addr", 32'(mem_addr), 32'h20);
        drive_instr(1'b1, 3'd2, 5'd9, 12'h000, 32'h00000000, 32'h0);
        tick();
        chk("busy.hold_addr", 32'(mem_addr), 32'h20);
        chk("busy.hold_wr", 32'(mem_wr), 32'd1);
        chk("busy.hold_wdata", mem_wdata, 32'h11112222);
        lsu_en = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("busy.done_en", 32'(mem_en), 32'd0);
        chk("busy.done_ready", 32'(lsu_ready), 32'd1);
        tick();
        chk("busy.no_second_en", 32'(mem_en), 32'd0);
        chk("busy.no_second_wb", 32'(regs_rd_wr), 32'd0);
        $display("[TB] sequence busy_ignore applied (tests=%0d failed=%0d)", n_tests, n_fail);

        // mem_ready while idle does nothing.
        mem_ready = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        chk("idle_rdy.mem_en", 32'(mem_en), 32'd0);
        chk("idle_rdy.wb", 32'(regs_rd_wr), 32'd0);
        tick();
        chk("idle_rdy.ready", 32'(lsu_ready), 32'd1);
        mem_ready = 1'b0;
        $display("[TB] sequence idle_mem_ready applied (tests=%0d failed=%0d)", n_tests, n_fail);

        // Reset in the middle of a load that is waiting on memory.
        drive_instr(1'b1, 3'd2, 5'd3, 12'h000, 32'h00000040, 32'h0);
        tick();
        lsu_en = 1'b0;
        chk("midrst.mem_en_before", 32'(mem_en), 32'd1);
        chk("midrst.addr_before", 32'(mem_addr), 32'h10);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("midrst.mem_en", 32'(mem_en), 32'd0);
        chk("midrst.ready", 32'(lsu_ready), 32'd1);
        chk("midrst.wb", 32'(regs_rd_wr), 32'd0);
        chk("midrst.mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst.mem_strb", 32'(mem_strb), 32'd0);
        chk("midrst.rd_val", regs_rd_val, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h33333333;
        tick();
        chk("midrst.no_wb1", 32'(regs_rd_wr), 32'd0);
        tick();
        chk("midrst.no_wb2", 32'(regs_rd_wr), 32'd0);
        chk("midrst.no_en", 32'(mem_en), 32'd0);
        mem_ready = 1'b0;
        $display("[TB] sequence reset_mid_access applied (tests=%0d failed=%0d)", n_tests, n_fail);
        run_vec(sw_after);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
